sd_otf_converter: RTL and testbench
===================================

Name: sd_otf_converter

Overview:
- Digit-serial on-the-fly converter: accepts signed-digit (SD) words MSD-first, one radix-2 digit per accepted beat, and produces the conventional two's-complement integer once the last digit arrives.
- Sits downstream of the online/parallel multiplier output stream, turning the redundant SD product (digit encoding {p,n}) back into binary for conventional logic.
- No carry-propagate adder: Q/QM register pair updated by concatenation each digit (Ercegovac-Lang on-the-fly conversion).

Parameters:
- NDIG, 8, digits per word (matches 2*WL product digits for N=4); >= 2.
- CW, $clog2(NDIG), digit counter width (localparam).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous abort; discards the partial word, returns to ACC
- in_valid  input  1  digit present
- in_ready  output  1  converter accepts a digit this cycle
- in_digit  input  2  SD digit {p,n}: 10=+1, 01=-1, 00=0, 11=0 (illegal)
- out_valid  output  1  converted word available
- out_ready  input  1  downstream takes the word
- out_data  output  NDIG+1  two's-complement value sum d_i*2^(NDIG-i), i=1..NDIG (d_1 = first digit)
- out_err  output  1  at least one 11 digit in this word

Behaviour:
- Reset (async, rst=1): state=ACC, cnt=0, Q=0, QM=all ones (-1), err=0, out_valid=0, out_data=0, out_err=0. in_ready=1 on the first cycle after reset release.
- States: ACC (collect digits) and DONE (hold result).
- ACC: in_ready=1, out_valid=0. Digit accepted when in_valid&in_ready. Per accepted digit d (registers NDIG+1 wide, left shift, drop MSB):
  - d=+1: Q<={Q,1}, QM<={Q,0}
  - d=0 or 11: Q<={Q,0}, QM<={QM,1}
  - d=-1: Q<={QM,1}, QM<={QM,0}
  - A 11 digit is treated as 0 and sets err.
  - cnt increments per accepted digit. On the digit with cnt==NDIG-1: next-state Q loads out_data, err|illegal loads out_err, out_valid<=1, state->DONE. Q, QM, cnt and err then reinitialise (0, -1, 0, 0).
- Latency: out_valid rises the cycle after the last digit is accepted.
- DONE: in_ready=0. out_data and out_err stay stable while out_valid=1 and out_ready=0. On out_valid&out_ready: out_valid<=0, state->ACC. in_ready=1 again the following cycle (no accept in the same cycle as the output handshake).
- out_data holds its last value after out_valid drops. It is not cleared.
- in_valid=0 in ACC: no register change. Gaps between digits are allowed, with unlimited length.
- clr=1 (either state): Q=0, QM=-1, cnt=0, err=0, out_valid=0, state=ACC. Any digit presented in that cycle is dropped. clr has priority over both handshakes.
- rst asserted mid-word or in DONE: immediate return to reset values. The partial word and any pending word are lost.
- Range: |value| <= 2^NDIG-1, so it always fits in NDIG+1 bits and cannot overflow. Invariant after every accepted digit: QM == Q-1 (mod 2^(NDIG+1)).
- Sequential storage: Q, QM, cnt, state, err, out_data, out_valid, out_err.

Test Plan:
- Reset, then 8 digits +1 (10) back-to-back, out_ready=1 -> out_valid one cycle after the 8th digit, out_data=0x0FF (255), out_err=0. The second word is accepted after the handshake.
- 8 digits -1 (01) -> out_data=0x101 (-255). Digits +1,-1,0,0,0,0,0,0 -> 0x040 (64). Digits 0 x7 then -1 -> 0x1FF (-1). Digits -1,+1,+1,+1,+1,+1,+1,+1 -> 0x1FF (-1), checking the QM path.
- Backpressure: the word completes while out_ready=0 for 3 cycles -> out_valid and out_data stay stable, in_ready=0 throughout. out_ready=1 -> out_valid falls, in_ready=1 the next cycle.
- Gapped input: in_valid toggles randomly across a word of alternating +1/-1 (+1 first) -> out_data=0x055 (85), with the same result as back-to-back input.
- Illegal digit: 11 in position 3 of an otherwise all-+1 word -> out_data=0x0DF (223), out_err=1. The next clean word -> out_err=0.
- Abort/reset: accept 3 digits, pulse clr (or assert rst asynchronously mid-cycle), then send a full all-+1 word -> 0x0FF, with no residue from the partial word. Random SD words are compared against a reference sum with QM==Q-1 checked every cycle.

Source files
------------

// File: rtl/sd_otf_converter.sv
// Digit-serial signed-digit to two's-complement converter (on-the-fly, Q/QM pair, no carry chain).
// Latency: out_valid rises the cycle after the last digit of a word is accepted.
// Backpressure: in_ready drops while a finished word waits; it returns the cycle after out_valid&out_ready.
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   clr                 synchronous abort of the partial/pending word (wins over both handshakes)
//   in_valid/in_ready   digit handshake, in_digit = {p,n}: 10=+1, 01=-1, 00/11=0 (11 flagged)
//   out_valid/out_ready word handshake, out_data = NDIG+1 bit two's complement, out_err = saw a 11 digit
module sd_otf_converter #(
  parameter int NDIG = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_digit,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NDIG:0]   out_data,
  output logic            out_err
);

  localparam int CW = $clog2(NDIG);
  localparam int W  = NDIG + 1;

  typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  q, qm;
  logic [W-1:0]  q_nxt, qm_nxt;
  logic          err;
  logic          accept;
  logic          last;
  logic          illegal;

  assign accept  = in_valid & in_ready & ~clr;
  assign last    = (cnt == CW'(NDIG - 1));
  assign illegal = (in_digit == 2'b11);

  // On-the-fly append: Q holds the converted prefix, QM = Q-1. A -1 digit
  // borrows from the prefix, which is exactly QM, so no carry ever ripples.
  always_comb begin
    q_nxt  = {q[W-2:0], 1'b0};
    qm_nxt = {qm[W-2:0], 1'b1};
    case (in_digit)
      2'b10: begin
        q_nxt  = {q[W-2:0], 1'b1};
        qm_nxt = {q[W-2:0], 1'b0};
      end
      2'b01: begin
        q_nxt  = {qm[W-2:0], 1'b1};
        qm_nxt = {qm[W-2:0], 1'b0};
      end
      default: begin
        q_nxt  = {q[W-2:0], 1'b0};
        qm_nxt = {qm[W-2:0], 1'b1};
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ACC;
    end else begin
      case (state)
        ACC:     if (accept && last)        state_nxt = DONE;
        DONE:    if (out_valid && out_ready) state_nxt = ACC;
        default:                             state_nxt = ACC;
      endcase
    end
  end

  // Output logic
  always_comb begin
    in_ready = (state == ACC);
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      q         <= '0;
      qm        <= '1;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (clr) begin
      // out_data/out_err deliberately keep their last value
      cnt       <= '0;
      q         <= '0;
      qm        <= '1;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (last) begin
          out_data  <= q_nxt;
          out_err   <= err | illegal;
          out_valid <= 1'b1;
          cnt       <= '0;
          q         <= '0;
          qm        <= '1;
          err       <= 1'b0;
        end else begin
          cnt <= cnt + CW'(1);
          q   <= q_nxt;
          qm  <= qm_nxt;
          err <= err | illegal;
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_otf_converter.sv
module tb_sd_otf_converter;

  localparam int NDIG = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            clr;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_digit;
  logic            out_valid;
  logic            out_ready;
  logic [NDIG:0]   out_data;
  logic            out_err;

  int n_checks = 0;
  int n_fail   = 0;

  // expected words: {err, data}
  logic [NDIG+1:0] sb_q[$];

  always #5 clk = ~clk;

  sd_otf_converter #(.NDIG(NDIG)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_digit (in_digit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expected word whenever the DUT completes an output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        logic [NDIG+1:0] e;
        e = sb_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e[NDIG:0]));
        chk("out_err", 32'(out_err), 32'(e[NDIG+1]));
      end
    end
  end

  // QM == Q-1 must hold at every cycle out of reset
  always @(negedge clk) begin
    if (!rst) begin
      logic [NDIG:0] diff;
      diff = dut.q - dut.qm;
      chk("qm_invariant", 32'(diff), 32'd1);
    end
  end

  task automatic send_digit(input logic [1:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_digit = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_digit = 2'($urandom_range(0, 3));
  endtask

  // digits packed MSD-first: first digit in the top two bits
  task automatic send_word(input logic [2*NDIG-1:0] digs, input logic [NDIG:0] exp_d,
                           input logic exp_e, input bit gaps);
    sb_q.push_back({exp_e, exp_d});
    for (int i = 0; i < NDIG; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      send_digit(digs[2*(NDIG-1-i) +: 2]);
    end
    @(negedge clk);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    chk("done_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_err"}, 32'(out_err), 32'd0);
  endtask

  function automatic logic [NDIG:0] ref_sum(input logic [2*NDIG-1:0] digs);
    int v;
    v = 0;
    for (int i = 0; i < NDIG; i++) begin
      case (digs[2*(NDIG-1-i) +: 2])
        2'b10:   v += (1 << (NDIG-1-i));
        2'b01:   v -= (1 << (NDIG-1-i));
        default: ;
      endcase
    end
    return v[NDIG:0];
  endfunction

  function automatic logic ref_err(input logic [2*NDIG-1:0] digs);
    logic e;
    e = 1'b0;
    for (int i = 0; i < NDIG; i++) e |= (digs[2*i +: 2] == 2'b11);
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2*NDIG-1:0] rw;
    int t;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_digit = 2'b00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    // Directed words, back-to-back input
    send_word(16'hAAAA, 9'h0FF, 1'b0, 1'b0);
    send_word(16'hAAAA, 9'h0FF, 1'b0, 1'b0);
    send_word(16'h5555, 9'h101, 1'b0, 1'b0);
    send_word(16'h9000, 9'h040, 1'b0, 1'b0);
    send_word(16'h0001, 9'h1FF, 1'b0, 1'b0);
    send_word(16'h6AAA, 9'h1FF, 1'b0, 1'b0);

    // Backpressure: word completes with out_ready low
    @(posedge clk); #1 out_ready = 1'b0;
    send_word(16'hAAAA, 9'h0FF, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h0FF);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("out_data_held", 32'(out_data), 32'h0FF);

    // Gapped input, same result as back-to-back
    send_word(16'h9999, 9'h055, 1'b0, 1'b1);
    send_word(16'h9999, 9'h055, 1'b0, 1'b0);

    // Illegal digit, then clean word clears the flag
    send_word(16'hAEAA, 9'h0DF, 1'b1, 1'b0);
    send_word(16'hAAAA, 9'h0FF, 1'b0, 1'b0);

    // Abort with clr; a digit offered during clr must be dropped
    for (int k = 0; k < 3; k++) send_digit(2'b01);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_digit = 2'b10;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    send_word(16'hAAAA, 9'h0FF, 1'b0, 1'b0);

    // Async reset mid-word
    for (int k = 0; k < 3; k++) send_digit(2'b10);
    #2 rst = 1'b1;
    #4 rst = 1'b0;
    check_reset_state("midword_reset");
    send_word(16'hAAAA, 9'h0FF, 1'b0, 1'b0);

    // Random SD words against the reference sum
    for (int w = 0; w < 10; w++) begin
      for (int i = 0; i < NDIG; i++) rw[2*i +: 2] = 2'($urandom_range(0, 3));
      send_word(rw, ref_sum(rw), ref_err(rw), (w % 2) == 1);
    end

    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
